// File: rtl/hci_l2_bank_adapter.sv
// hci_l2_bank_adapter: L2 interconnect bank port to SRAM macro, with a fixed-latency
// response pipe and an idle-driven retention controller (ACTIVE -> SLEEP -> WAKE).
module hci_l2_bank_adapter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int IW       = 20,
    parameter int SRAM_AW  = 12,
    parameter int RD_LAT   = 1,
    parameter int IDLE_CYC = 64,
    parameter int WAKE_CYC = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sleep_en_i,
    input  logic               req_i,
    input  logic [AW-1:0]      add_i,
    input  logic               wen_i,
    input  logic [DW-1:0]      data_i,
    input  logic [DW/8-1:0]    be_i,
    input  logic [IW-1:0]      id_i,
    output logic               gnt_o,
    output logic               r_valid_o,
    output logic [IW-1:0]      r_id_o,
    output logic [DW-1:0]      r_data_o,
    output logic               sram_ce_o,
    output logic               sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [DW-1:0]      sram_wdata_o,
    output logic [DW/8-1:0]    sram_be_o,
    input  logic [DW-1:0]      sram_rdata_i,
    output logic               sram_ret_o,
    output logic               sleep_o
);
    localparam logic [1:0] ACTIVE = 2'd0;
    localparam logic [1:0] SLEEP  = 2'd1;
    localparam logic [1:0] WAKE   = 2'd2;
    localparam int ICW = $clog2(IDLE_CYC);
    localparam int WCW = $clog2(WAKE_CYC + 1);

    logic [1:0]                state_q, state_d;
    logic [ICW-1:0]            idle_q, idle_d;
    logic [WCW-1:0]            wake_q, wake_d;
    logic [RD_LAT-1:0]         vld_q, vld_d, rd_q, rd_d;
    logic [RD_LAT-1:0][IW-1:0] id_q, id_d;
    logic                      acc, empty, unused_add;

    assign gnt_o        = state_q == ACTIVE;
    assign acc          = req_i && gnt_o;
    assign sram_ce_o    = acc;
    assign sram_we_o    = acc && !wen_i;
    assign sram_addr_o  = add_i[SRAM_AW+1:2];
    assign sram_wdata_o = data_i;
    assign sram_be_o    = be_i;
    assign unused_add   = ^add_i;
    assign sram_ret_o   = state_q == SLEEP;
    assign sleep_o      = state_q != ACTIVE;

    // Response pipe: stage 0 captures the accept, the last stage is the response
    assign vld_d     = RD_LAT'({vld_q, acc});
    assign rd_d      = RD_LAT'({rd_q, acc && wen_i});
    assign id_d      = (RD_LAT*IW)'({id_q, id_i});
    assign empty     = ~|vld_q;
    assign r_valid_o = vld_q[RD_LAT-1];
    assign r_id_o    = id_q[RD_LAT-1];
    assign r_data_o  = (r_valid_o && rd_q[RD_LAT-1]) ? sram_rdata_i : '0;

    always_comb begin
        state_d = state_q;
        idle_d  = '0;
        wake_d  = '0;
        if (state_q == ACTIVE) begin
            if (sleep_en_i && !req_i && idle_q == ICW'(IDLE_CYC - 1)) state_d = SLEEP;
            if (sleep_en_i && !req_i && empty)
                idle_d = (idle_q == ICW'(IDLE_CYC - 1)) ? idle_q : idle_q + 1'b1;
        end else if (state_q == SLEEP) begin
            if (req_i || !sleep_en_i) state_d = WAKE;
        end else if (wake_q == WCW'(WAKE_CYC - 1)) begin
            state_d = ACTIVE;
        end else begin
            wake_d = wake_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACTIVE;
            idle_q  <= '0;
            wake_q  <= '0;
            vld_q   <= '0;
            rd_q    <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            vld_q   <= vld_d;
            rd_q    <= rd_d;
            id_q    <= id_d;
        end
    end
endmodule

// File: tb/tb_hci_l2_bank_adapter.sv
// tb_hci_l2_bank_adapter: directed scenarios plus randomized traffic, checked every cycle
// against a queue/timestamp model of responses, memory contents and retention state.
module tb_hci_l2_bank_adapter;
    localparam int RD_LAT   = 2;
    localparam int IDLE_CYC = 8;
    localparam int WAKE_CYC = 4;
    localparam int M_ACT = 0, M_SLP = 1, M_WAK = 2;

    logic        clk = 0, rst_n, sleep_en, req, wen;
    logic [31:0] add, wdat;
    logic [3:0]  be;
    logic [19:0] id;
    logic        gnt, r_valid, ce, we, ret, slp;
    logic [19:0] r_id;
    logic [31:0] r_data, swdata, srdata;
    logic [11:0] saddr;
    logic [3:0]  sbe;

    int n_tests = 0, n_fail = 0, cyc = 0;

    always #5 clk = ~clk;

    hci_l2_bank_adapter #(.AW(32), .DW(32), .IW(20), .SRAM_AW(12), .RD_LAT(RD_LAT),
                          .IDLE_CYC(IDLE_CYC), .WAKE_CYC(WAKE_CYC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sleep_en_i(sleep_en), .req_i(req), .add_i(add),
        .wen_i(wen), .data_i(wdat), .be_i(be), .id_i(id), .gnt_o(gnt), .r_valid_o(r_valid),
        .r_id_o(r_id), .r_data_o(r_data), .sram_ce_o(ce), .sram_we_o(we), .sram_addr_o(saddr),
        .sram_wdata_o(swdata), .sram_be_o(sbe), .sram_rdata_i(srdata), .sram_ret_o(ret),
        .sleep_o(slp)
    );

    function automatic logic [31:0] init_word(input int i);
        return i * 32'h9E3779B9 ^ 32'h5A5A0000;
    endfunction

    // Behavioural SRAM: read data appears RD_LAT cycles after the ce cycle, garbage otherwise
    logic [31:0] sram_mem [4096];
    logic [31:0] rpipe [RD_LAT];
    assign srdata = rpipe[RD_LAT-1];
    initial for (int i = 0; i < 4096; i++) sram_mem[i] <= init_word(i);
    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= (ce && !we) ? sram_mem[saddr] : $urandom();
        if (ce && we)
            for (int b = 0; b < 4; b++) if (sbe[b]) sram_mem[saddr][8*b+:8] <= swdata[8*b+:8];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model
    typedef struct { int due; logic [19:0] id; logic rd; logic [31:0] data; } resp_t;
    resp_t       resp_q [$];
    logic [31:0] mem_m [4096];
    int          mode = M_ACT, quiet = 0, wake_left = 0;
    initial for (int i = 0; i < 4096; i++) mem_m[i] = init_word(i);

    always @(negedge clk) begin
        bit          acc_m, infl;
        logic [11:0] a;
        resp_t       r;
        if (!rst_n) begin
            chk("rst_gnt", gnt, 1);
            chk("rst_rvalid", r_valid, 0);
            chk("rst_rid", r_id, 0);
            chk("rst_ret", ret, 0);
            chk("rst_sleep", slp, 0);
            resp_q.delete();
            mode = M_ACT;
            quiet = 0;
        end else begin
            acc_m = req && mode == M_ACT;
            a = add[13:2];
            chk("gnt", gnt, mode == M_ACT);
            chk("ce", ce, acc_m);
            chk("we", we, acc_m && !wen);
            chk("ret", ret, mode == M_SLP);
            chk("sleep", slp, mode != M_ACT);
            if (acc_m) begin
                chk("addr", saddr, a);
                chk("wdata", swdata, wdat);
                chk("be", sbe, be);
            end
            infl = resp_q.size() != 0;
            if (infl && resp_q[0].due == cyc) begin
                r = resp_q.pop_front();
                chk("rvalid", r_valid, 1);
                chk("rid", r_id, r.id);
                chk("rdata", r_data, r.rd ? r.data : 32'h0);
            end else begin
                chk("rvalid", r_valid, 0);
                chk("rdata_idle", r_data, 0);
            end
            if (acc_m) begin
                resp_q.push_back('{cyc + RD_LAT, id, wen, wen ? mem_m[a] : 32'h0});
                if (!wen) for (int b = 0; b < 4; b++) if (be[b]) mem_m[a][8*b+:8] = wdat[8*b+:8];
            end
            if (mode == M_ACT) begin
                if (sleep_en && !req && quiet >= IDLE_CYC - 1) begin
                    mode = M_SLP;
                    quiet = 0;
                end else quiet = (sleep_en && !req && !infl) ? quiet + 1 : 0;
            end else if (mode == M_SLP) begin
                if (req || !sleep_en) begin
                    mode = M_WAK;
                    wake_left = WAKE_CYC;
                end
            end else begin
                wake_left--;
                if (wake_left == 0) mode = M_ACT;
            end
        end
        cyc++;
    end

    task automatic nx(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask
    task automatic rq(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [19:0] i);
        req = r; wen = w; add = a; wdat = d; be = b; id = i;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          p;
        bit          se_ph, acc_last;
        rst_n = 1; sleep_en = 1;
        rq(0, 1, 0, 0, 0, 0);
        #1 rst_n = 0;
        repeat (2) nx();
        smp();
        chk("t0_gnt", gnt, 1);
        chk("t0_rvalid", r_valid, 0);
        chk("t0_sleep", slp, 0);
        // T1: write then read back at 0x40
        nx(); rst_n = 1;
        rq(1, 0, 32'h40, 32'hDEADBEEF, 4'hF, 20'd3);
        smp();
        chk("t1_we", we, 1);
        chk("t1_addr", saddr, 12'h010);
        nx(); rq(0, 1, 0, 0, 0, 0);
        smp(); nx(); smp();
        chk("t1_wr_rvalid", r_valid, 1);
        chk("t1_wr_rid", r_id, 3);
        chk("t1_wr_rdata", r_data, 0);
        nx(); rq(1, 1, 32'h40, 0, 0, 20'd5);
        smp(); nx(); rq(0, 1, 0, 0, 0, 0);
        smp(); nx(); smp();
        chk("t1_rd_rvalid", r_valid, 1);
        chk("t1_rd_rid", r_id, 5);
        chk("t1_rd_rdata", r_data, 32'hDEADBEEF);
        // T2: 8 back-to-back reads, then T3: quiet until sleep
        for (int i = 0; i < 19; i++) begin
            nx();
            if (i < 8) rq(1, 1, {$urandom_range(0, 255), 24'h0} | (i << 2), 0, 0, 20'(i));
            else rq(0, 1, 0, 0, 0, 0);
            smp();
            if (i < 8) chk("t2_gnt", gnt, 1);
            chk("t2_rvalid", r_valid, i >= 2 && i < 10);
            if (i >= 2 && i < 10) chk("t2_rid", r_id, 20'(i - 2));
            chk("t3_sleep", slp, i >= 18);
        end
        repeat (2) begin nx(); smp(); chk("t3_ret", ret, 1); end
        nx(); rq(1, 1, 32'h80, 0, 0, 20'd9);
        smp();
        chk("t3_s_gnt", gnt, 0);
        chk("t3_s_ce", ce, 0);
        for (int k = 1; k <= 5; k++) begin
            nx(); smp();
            chk("t3_ret_low", ret, 0);
            chk("t3_wake_gnt", gnt, k == 5);
            chk("t3_wake_ce", ce, k == 5);
        end
        // T4: request in the last idle cycle blocks sleep entry and restarts the count
        for (int m = 1; m <= 21; m++) begin
            nx();
            if (m == 10) rq(1, 0, 32'hC4, $urandom(), 4'h3, 20'd11);
            else rq(0, 1, 0, 0, 0, 0);
            smp();
            if (m == 10) chk("t4_ce", ce, 1);
            chk("t4_sleep", slp, m == 21);
        end
        // T5: drop sleep_en in SLEEP, toggles during WAKE ignored, then long idle without sleep
        nx(); sleep_en = 0;
        smp();
        chk("t5_ret", ret, 1);
        for (int w = 1; w <= 5; w++) begin
            nx();
            sleep_en = (w == 2);
            smp();
            chk("t5_sleep", slp, w < 5);
            chk("t5_gnt", gnt, w == 5);
        end
        for (int k = 0; k < 200; k++) begin nx(); smp(); chk("t5_stay", slp, 0); end
        // T6: reset with two reads in flight
        nx(); sleep_en = 1; rq(1, 1, 32'h10, 0, 0, 20'd21);
        smp(); nx(); rq(1, 1, 32'h14, 0, 0, 20'd22);
        smp(); nx(); rst_n = 0; rq(0, 1, 0, 0, 0, 0);
        smp(); nx(); smp(); nx(); rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("t6_rvalid", r_valid, 0);
            chk("t6_gnt", gnt, 1);
            chk("t6_ret", ret, 0);
            nx();
        end
        // Randomized traffic with quiet phases, sleep_en changes and one mid-run reset
        p = 0; se_ph = 1; acc_last = 1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: p = 0;
                    1: p = 10;
                    2: p = 50;
                    default: p = 90;
                endcase
                se_ph = $urandom_range(0, 3) != 0;
            end
            sleep_en = se_ph ^ ($urandom_range(0, 31) == 0);
            if (n == 1500) begin rst_n = 0; rq(0, 1, 0, 0, 0, 0); end
            if (n == 1503) rst_n = 1;
            if (rst_n && !(req && !acc_last)) begin
                a = $urandom();
                a[13:6] = '0;
                rq($urandom_range(0, 99) < p, 1'($urandom()), a, $urandom(), 4'($urandom()),
                   20'($urandom()));
            end
            smp();
            acc_last = req && gnt;
            nx();
        end
        rq(0, 1, 0, 0, 0, 0);
        repeat (4) begin smp(); nx(); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
